// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed eight-digit seven-segment driver. Inputs are copied into shadow
// registers once per frame, so a digit never shows a half-updated value.
module sevenseg_scan_driver #(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(DIGIT_TICKS - 1);

  logic [PW-1:0] presc_reg;
  logic [2:0]    index_reg;
  logic [31:0]   shadow_digits_reg;
  logic [7:0]    shadow_en_reg;
  logic [7:0]    shadow_dp_reg;

  logic       tick;
  logic       frame_end;
  logic [3:0] nibble [8];
  logic [3:0] cur_nibble;
  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign tick      = (presc_reg == LAST_TICK);
  assign frame_end = tick && (index_reg == 3'd7);

  for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
    assign nibble[gi] = shadow_digits_reg[4*gi +: 4];
  end

  assign cur_nibble = nibble[index_reg];

  // Active-low {G,F,E,D,C,B,A}; non-BCD codes show a lone dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (shadow_en_reg[index_reg] && !blank) begin
      an_next  = ~(8'b1 << index_reg);
      seg_next = decode(cur_nibble);
      dp_next  = ~shadow_dp_reg[index_reg];
    end
  end

  // Blank only gates the registered outputs; timing and capture keep running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_reg         <= '0;
      index_reg         <= 3'd0;
      shadow_digits_reg <= 32'd0;
      shadow_en_reg     <= 8'd0;
      shadow_dp_reg     <= 8'd0;
      frame_start       <= 1'b0;
      an                <= 8'hFF;
      seg               <= 7'h7F;
      dp                <= 1'b1;
    end else begin
      presc_reg   <= tick ? '0 : presc_reg + 1'b1;
      frame_start <= frame_end;
      if (tick) begin
        index_reg <= index_reg + 3'd1;
      end
      if (frame_end) begin
        shadow_digits_reg <= digits;
        shadow_en_reg     <= digit_en;
        shadow_dp_reg     <= dp_en;
      end
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver at DIGIT_TICKS=4: expected outputs are
// queued per (reset epoch, edge count) and a monitor compares them on each falling edge.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] digits = 32'd0;
  logic [7:0]  digit_en = 8'd0;
  logic [7:0]  dp_en = 8'd0;
  logic        blank = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  sevenseg_scan_driver #(.DIGIT_TICKS(4)) dut (
    .clk(clk), .resetn(resetn), .digits(digits), .digit_en(digit_en),
    .dp_en(dp_en), .blank(blank), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ep;
    int         tag;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int epoch = 0;
  int e = 0;
  bit in_reset = 1'b0;

  // Edge counter since the latest reset release; each reset entry opens a new epoch.
  always @(posedge clk) begin
    if (!resetn) begin
      if (!in_reset) epoch++;
      in_reset = 1'b1;
      e = 0;
    end else begin
      in_reset = 1'b0;
      e++;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL onehot ep=%0d e=%0d an=%h (at most one low bit required)", epoch, e, an);
    end
    while (q.size() > 0 && (q[0].ep < epoch || (q[0].ep == epoch && q[0].tag < e))) begin
      checks++;
      errors++;
      $display("FAIL missed ep=%0d e=%0d entry never sampled", q[0].ep, q[0].tag);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].ep == epoch && q[0].tag == e) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (an !== x.an || seg !== x.seg || dp !== x.dp || frame_start !== x.fs) begin
        errors++;
        $display("FAIL out ep=%0d e=%0d got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                 epoch, e, an, seg, dp, frame_start, x.an, x.seg, x.dp, x.fs);
      end else begin
        $display("ok ep=%0d e=%0d an=%h seg=%h dp=%b fs=%b", epoch, e, an, seg, dp, frame_start);
      end
    end
  end

  task automatic push_range(input int ep, input int lo, input int hi, input logic [7:0] a,
                            input logic [6:0] s, input logic d, input logic f);
    for (int i = lo; i <= hi; i++) begin
      exp_t x;
      x.ep = ep; x.tag = i; x.an = a; x.seg = s; x.dp = d; x.fs = f;
      q.push_back(x);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_e(input int ep, input int n);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(epoch == ep && e == n) && cnt < 2000);
    if (!(epoch == ep && e == n)) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting ep=%0d e=%0d got ep=%0d e=%0d", ep, n, epoch, e);
      finish_run();
    end
  endtask

  // Digits 0x123 with en=0x07, dp_en=0x02: one 32-cycle frame after the boundary at base.
  task automatic push_frame123(input int ep, input int base);
    push_range(ep, base+1,  base+4,  8'hFE, 7'h30, 1'b1, 1'b0);
    push_range(ep, base+5,  base+8,  8'hFD, 7'h24, 1'b0, 1'b0);
    push_range(ep, base+9,  base+12, 8'hFB, 7'h79, 1'b1, 1'b0);
    push_range(ep, base+13, base+31, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(ep, base+32, base+32, 8'hFF, 7'h7F, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset held with random inputs: dark, no frame_start.
    push_range(1, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      digits   = $urandom;
      digit_en = 8'($urandom);
      dp_en    = 8'($urandom);
      blank    = 1'($urandom);
    end
    digits = 32'h0000_0123; digit_en = 8'h07; dp_en = 8'h02; blank = 1'b0;
    resetn = 1'b1;
    // First partial frame dark, capture at edge 32, then two identical frames.
    push_range(1, 1, 31, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 32, 32, 8'hFF, 7'h7F, 1'b1, 1'b1);
    push_frame123(1, 32);
    push_frame123(1, 64);

    // Tear-free: mid-frame change shows only after the next capture.
    wait_e(1, 70);
    #1 digits = 32'h0000_0999;
    push_range(1, 97,  100, 8'hFE, 7'h10, 1'b1, 1'b0);
    push_range(1, 101, 104, 8'hFD, 7'h10, 1'b0, 1'b0);
    push_range(1, 105, 108, 8'hFB, 7'h10, 1'b1, 1'b0);
    push_range(1, 109, 127, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 128, 128, 8'hFF, 7'h7F, 1'b1, 1'b1);

    // Invalid BCD nibble shows a dash.
    wait_e(1, 100);
    #1 digits = 32'h0000_000A; digit_en = 8'h01; dp_en = 8'h00;
    push_range(1, 129, 132, 8'hFE, 7'h3F, 1'b1, 1'b0);
    push_range(1, 133, 159, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 160, 160, 8'hFF, 7'h7F, 1'b1, 1'b1);

    // Blank for 10 cycles across digits 0..2 of the next frame.
    wait_e(1, 140);
    #1 digits = 32'h0000_0123; digit_en = 8'h07; dp_en = 8'h02;
    push_range(1, 161, 161, 8'hFE, 7'h30, 1'b1, 1'b0);
    push_range(1, 162, 171, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 172, 172, 8'hFB, 7'h79, 1'b1, 1'b0);
    push_range(1, 173, 191, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(1, 192, 192, 8'hFF, 7'h7F, 1'b1, 1'b1);
    wait_e(1, 161);
    #1 blank = 1'b1;
    wait_e(1, 171);
    #1 blank = 1'b0;

    // All eight digits enabled, then reset pulled during index 5.
    wait_e(1, 175);
    #1 digits = 32'h8765_4321; digit_en = 8'hFF; dp_en = 8'h00;
    push_range(1, 193, 196, 8'hFE, 7'h79, 1'b1, 1'b0);
    push_range(1, 197, 200, 8'hFD, 7'h24, 1'b1, 1'b0);
    push_range(1, 201, 204, 8'hFB, 7'h30, 1'b1, 1'b0);
    push_range(1, 205, 208, 8'hF7, 7'h19, 1'b1, 1'b0);
    push_range(1, 209, 212, 8'hEF, 7'h12, 1'b1, 1'b0);
    push_range(1, 213, 213, 8'hDF, 7'h02, 1'b1, 1'b0);
    push_range(1, 214, 214, 8'hFF, 7'h7F, 1'b1, 1'b0);
    wait_e(1, 213);
    @(posedge clk);
    #2 resetn = 1'b0;
    digits = 32'h0000_0456; digit_en = 8'h07; dp_en = 8'h00;
    push_range(2, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(2, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(2, 0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    push_range(2, 1, 31, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push_range(2, 32, 32, 8'hFF, 7'h7F, 1'b1, 1'b1);
    push_range(2, 33, 36, 8'hFE, 7'h02, 1'b1, 1'b0);
    push_range(2, 37, 40, 8'hFD, 7'h12, 1'b1, 1'b0);
    push_range(2, 41, 44, 8'hFB, 7'h19, 1'b1, 1'b0);
    push_range(2, 45, 48, 8'hFF, 7'h7F, 1'b1, 1'b0);

    begin
      int cnt = 0;
      while (q.size() > 0 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
    end
    #1;
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover ep=%0d e=%0d expectation never checked", q[0].ep, q[0].tag);
      void'(q.pop_front());
    end
    finish_run();
  end

endmodule
